// File: rtl/ctrl_decode_unit.sv
// ctrl_decode_unit: ARM-style instruction decoder with condition evaluation, CPSR flag register and one-slot branch squash.
// Revision 1.0 - initial release.
`default_nettype none

module ctrl_decode_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  flags_wd,
  output logic [3:0]  alu_op,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  cpsr_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        ib,
  output logic [31:0] bv,
  output logic        bl,
  output logic [31:0] cpsr,
  output logic        branch_pending
);

  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_pass;
  logic       squash;
  logic [3:0] cpsr_we_raw;
  logic       reg_we_raw, mem_we_raw, ib_raw, bl_raw;
  logic [3:0] dp_op;

  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign dp_op = instr[24:21];

  always_comb begin
    cond_pass = 1'b0;
    case (instr[31:28])
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // The slot after a taken branch is squashed regardless of its condition.
  assign squash = ~cond_pass | branch_pending;

  always_comb begin
    alu_op      = 4'b0000;
    rn          = instr[19:16];
    rd          = instr[15:12];
    cpsr_we_raw = 4'b0000;
    reg_we_raw  = 1'b0;
    mem_we_raw  = 1'b0;
    ib_raw      = 1'b0;
    bl_raw      = 1'b0;
    bv          = 32'd0;
    if (instr[27:26] == 2'b00) begin
      alu_op     = dp_op;
      reg_we_raw = (dp_op[3:2] != 2'b10);
      // Compare/test opcodes always update flags; others only with S set.
      if (instr[20] || dp_op[3:2] == 2'b10) begin
        if ((dp_op >= 4'b0010 && dp_op <= 4'b0111) || dp_op == 4'b1010 || dp_op == 4'b1011)
          cpsr_we_raw = 4'b1111;
        else
          cpsr_we_raw = 4'b1100;
      end
    end else if (instr[27:26] == 2'b01) begin
      alu_op     = instr[23] ? 4'b0100 : 4'b0010;
      reg_we_raw = instr[20];
      mem_we_raw = ~instr[20];
    end else if (instr[27:25] == 3'b101) begin
      ib_raw = 1'b1;
      bl_raw = instr[24];
      bv     = {{6{instr[23]}}, instr[23:0], 2'b00};
      if (instr[24]) begin
        rd         = 4'd14;
        reg_we_raw = 1'b1;
      end
    end
  end

  assign cpsr_we = squash ? 4'b0000 : cpsr_we_raw;
  assign reg_we  = reg_we_raw & ~squash;
  assign mem_we  = mem_we_raw & ~squash;
  assign ib      = ib_raw & ~squash;
  assign bl      = bl_raw & ~squash;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      branch_pending <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cpsr_we[i]) flags_q[i] <= flags_wd[i];
      end
      branch_pending <= ib;
    end
  end

  assign cpsr = {flags_q, 28'd0};

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode_unit.sv
// tb_ctrl_decode_unit: directed self-checking bench for ctrl_decode_unit.
// Revision 1.0 - initial release.
`default_nettype none

module tb_ctrl_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  flags_wd;
  logic [3:0]  alu_op, rn, rd, cpsr_we;
  logic        reg_we, mem_we, ib, bl, branch_pending;
  logic [31:0] bv, cpsr;

  int checks = 0;
  int errors = 0;

  ctrl_decode_unit dut (
    .clk(clk), .reset(reset), .instr(instr), .flags_wd(flags_wd),
    .alu_op(alu_op), .rn(rn), .rd(rd), .cpsr_we(cpsr_we),
    .reg_we(reg_we), .mem_we(mem_we), .ib(ib), .bv(bv), .bl(bl),
    .cpsr(cpsr), .branch_pending(branch_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Fields: {alu_op, rn, rd, cpsr_we} and {reg_we, mem_we, ib, bl}
  task automatic test_reset();
    reset = 1'b1; instr = 32'h0000_0000; flags_wd = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    checks++; if (cpsr !== 32'h0) begin errors++; $display("FAIL reset_cpsr got %h exp %h", cpsr, 32'h0); end
    checks++; if (branch_pending !== 1'b0) begin errors++; $display("FAIL reset_bp got %b exp 0", branch_pending); end
    instr = 32'hE092_1003; flags_wd = 4'b1111;
    tick();
    checks++; if (cpsr !== 32'hF000_0000) begin errors++; $display("FAIL preload_cpsr got %h exp F0000000", cpsr); end
    reset = 1'b1; settle();
    checks++; if (cpsr_we !== 4'b1111) begin errors++; $display("FAIL reset_comb_we got %b exp 1111", cpsr_we); end
    tick();
    checks++; if (cpsr !== 32'h0) begin errors++; $display("FAIL reset_override got %h exp 00000000", cpsr); end
    instr = 32'hEAFF_FFFE; settle();
    checks++; if (ib !== 1'b1) begin errors++; $display("FAIL reset_comb_ib got %b exp 1", ib); end
    tick();
    checks++; if (branch_pending !== 1'b0) begin errors++; $display("FAIL reset_bp_override got %b exp 0", branch_pending); end
    reset = 1'b0; instr = 32'h0000_0000; flags_wd = 4'b0000;
    tick();
  endtask

  task automatic test_adds();
    instr = 32'hE092_1003; flags_wd = 4'b0100; settle();
    checks++; if ({alu_op, rn, rd, cpsr_we} !== 16'h421F) begin errors++; $display("FAIL adds_fields got %h exp 421F", {alu_op, rn, rd, cpsr_we}); end
    checks++; if ({reg_we, mem_we, ib, bl} !== 4'b1000) begin errors++; $display("FAIL adds_en got %b exp 1000", {reg_we, mem_we, ib, bl}); end
    checks++; if (bv !== 32'h0) begin errors++; $display("FAIL adds_bv got %h exp 00000000", bv); end
    tick();
    checks++; if (cpsr !== 32'h4000_0000) begin errors++; $display("FAIL adds_cpsr got %h exp 40000000", cpsr); end
    flags_wd = 4'b0000;
  endtask

  task automatic test_back_to_back();
    instr = 32'hEAFF_FFFE; settle();
    checks++; if ({ib, bl, bv} !== {2'b10, 32'hFFFF_FFF8}) begin errors++; $display("FAIL b_taken got ib=%b bl=%b bv=%h exp ib=1 bl=0 bv=FFFFFFF8", ib, bl, bv); end
    tick();
    checks++; if (branch_pending !== 1'b1) begin errors++; $display("FAIL b_pending got %b exp 1", branch_pending); end
    settle();
    checks++; if ({ib, bv} !== {1'b0, 32'hFFFF_FFF8}) begin errors++; $display("FAIL b_second_squash got ib=%b bv=%h exp ib=0 bv=FFFFFFF8", ib, bv); end
    instr = 32'hE082_1003; settle();
    checks++; if ({reg_we, cpsr_we, alu_op} !== {1'b0, 4'b0000, 4'b0100}) begin errors++; $display("FAIL slot_squash got we=%b cwe=%b op=%h exp we=0 cwe=0000 op=4", reg_we, cpsr_we, alu_op); end
    tick();
    checks++; if (branch_pending !== 1'b0) begin errors++; $display("FAIL bp_clear got %b exp 0", branch_pending); end
    settle();
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL add_after got %b exp 1", reg_we); end
    instr = 32'hEA80_0000; settle();
    checks++; if (bv !== 32'hFE00_0000) begin errors++; $display("FAIL b_minoffset got %h exp FE000000", bv); end
    instr = 32'hE082_1003;
    tick();
  endtask

  task automatic test_cond();
    instr = 32'hE151_0002; flags_wd = 4'b0000; settle();
    checks++; if ({reg_we, cpsr_we, alu_op} !== {1'b0, 4'b1111, 4'b1010}) begin errors++; $display("FAIL cmp got we=%b cwe=%b op=%h exp we=0 cwe=1111 op=A", reg_we, cpsr_we, alu_op); end
    tick();
    instr = 32'h0A00_0001; settle();
    checks++; if ({ib, bv} !== {1'b0, 32'h4}) begin errors++; $display("FAIL beq_z0 got ib=%b bv=%h exp ib=0 bv=00000004", ib, bv); end
    instr = 32'hE151_0002; flags_wd = 4'b0100;
    tick();
    instr = 32'h0A00_0001; settle();
    checks++; if ({ib, bv} !== {1'b1, 32'h4}) begin errors++; $display("FAIL beq_z1 got ib=%b bv=%h exp ib=1 bv=00000004", ib, bv); end
    instr = 32'h1A00_0001; settle();
    checks++; if (ib !== 1'b0) begin errors++; $display("FAIL bne_z1 got %b exp 0", ib); end
    instr = 32'hE151_0002; flags_wd = 4'b1011;
    tick();
    checks++; if (cpsr !== 32'hB000_0000) begin errors++; $display("FAIL cmp_cpsr got %h exp B0000000", cpsr); end
    instr = 32'hAA00_0000; settle();
    checks++; if (ib !== 1'b1) begin errors++; $display("FAIL bge got %b exp 1", ib); end
    instr = 32'hBA00_0000; settle();
    checks++; if (ib !== 1'b0) begin errors++; $display("FAIL blt got %b exp 0", ib); end
    instr = 32'h8A00_0000; settle();
    checks++; if (ib !== 1'b1) begin errors++; $display("FAIL bhi got %b exp 1", ib); end
    instr = 32'hFA00_0000; settle();
    checks++; if (ib !== 1'b0) begin errors++; $display("FAIL bnv got %b exp 0", ib); end
  endtask

  task automatic test_logical();
    instr = 32'hE011_0002; flags_wd = 4'b0100; settle();
    checks++; if ({alu_op, rn, rd, cpsr_we} !== 16'h010C || reg_we !== 1'b1) begin errors++; $display("FAIL ands got %h we=%b exp 010C we=1", {alu_op, rn, rd, cpsr_we}, reg_we); end
    tick();
    checks++; if (cpsr !== 32'h7000_0000) begin errors++; $display("FAIL ands_partial got %h exp 70000000", cpsr); end
    instr = 32'hE111_0002; settle();
    checks++; if ({alu_op, cpsr_we, reg_we} !== {4'b1000, 4'b1100, 1'b0}) begin errors++; $display("FAIL tst got op=%h cwe=%b we=%b exp op=8 cwe=1100 we=0", alu_op, cpsr_we, reg_we); end
    flags_wd = 4'b0000;
    instr = 32'hE001_0002; settle();
    checks++; if ({cpsr_we, reg_we} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL and_nos got cwe=%b we=%b exp cwe=0000 we=1", cpsr_we, reg_we); end
  endtask

  task automatic test_ldst();
    instr = 32'hE581_2000; settle();
    checks++; if ({alu_op, rn, rd, cpsr_we} !== 16'h4120 || {reg_we, mem_we, ib, bl} !== 4'b0100 || bv !== 32'h0) begin errors++; $display("FAIL str got %h en=%b bv=%h exp 4120 en=0100 bv=0", {alu_op, rn, rd, cpsr_we}, {reg_we, mem_we, ib, bl}, bv); end
    instr = 32'hE591_2000; settle();
    checks++; if ({reg_we, mem_we} !== 2'b10) begin errors++; $display("FAIL ldr got %b exp 10", {reg_we, mem_we}); end
    instr = 32'hE501_2000; settle();
    checks++; if (alu_op !== 4'b0010) begin errors++; $display("FAIL str_sub got %h exp 2", alu_op); end
  endtask

  task automatic test_bl();
    instr = 32'hEB00_0002; settle();
    checks++; if ({reg_we, mem_we, ib, bl} !== 4'b1011 || rd !== 4'd14 || bv !== 32'h8) begin errors++; $display("FAIL bl got en=%b rd=%0d bv=%h exp en=1011 rd=14 bv=00000008", {reg_we, mem_we, ib, bl}, rd, bv); end
    tick();
    settle();
    checks++; if ({reg_we, ib, bl, rd} !== {3'b000, 4'd14}) begin errors++; $display("FAIL bl_squash got we=%b ib=%b bl=%b rd=%0d exp 0 0 0 14", reg_we, ib, bl, rd); end
    instr = 32'hE082_1003;
    tick();
  endtask

  task automatic test_other();
    instr = 32'hEE12_3004; settle();
    checks++; if ({alu_op, cpsr_we} !== 8'h00 || {reg_we, mem_we, ib, bl} !== 4'b0000 || bv !== 32'h0) begin errors++; $display("FAIL other got op=%h cwe=%b en=%b bv=%h exp all 0", alu_op, cpsr_we, {reg_we, mem_we, ib, bl}, bv); end
    instr = 32'hF082_1003; settle();
    checks++; if ({reg_we, alu_op} !== {1'b0, 4'b0100}) begin errors++; $display("FAIL nv_squash got we=%b op=%h exp we=0 op=4", reg_we, alu_op); end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_back_to_back();
    test_cond();
    test_logical();
    test_ldst();
    test_bl();
    test_other();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
